// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: fetch FSM encoding and fetch-stage reset constants.
package riscv_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues one imem request at a time, holds the fetched word
// for decode, and squashes in-flight fetches when execute redirects the PC.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instr,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [31:0]  instr_pc,
    output logic [31:0]  pc_plus4,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         misaligned,
    output fetch_state_t state_dbg
);

    // Handshakes: imem_req/imem_addr hold steady until imem_gnt is seen in the same cycle;
    // imem_rvalid is honoured only in WAIT; instr is consumed when instr_valid && instr_ready.

    fetch_state_t state_q, state_n;
    logic [31:0]  pc_q, pc_n;
    logic [31:0]  instr_q, instr_n;
    logic [31:0]  instr_pc_q, instr_pc_n;
    logic         squash_q, squash_n;
    logic         mis_q, mis_n;
    logic         redirect_ok;
    logic         target_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            squash_q   <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            pc_q       <= pc_n;
            instr_q    <= instr_n;
            instr_pc_q <= instr_pc_n;
            squash_q   <= squash_n;
            mis_q      <= mis_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        pc_n        = pc_q;
        instr_n     = instr_q;
        instr_pc_n  = instr_pc_q;
        squash_n    = squash_q;
        mis_n       = mis_q;
        redirect_ok = redirect && (state_q != HALT);
        target_bad  = (redirect_pc[1:0] != 2'b00);

        if (redirect_ok) begin
            instr_n = NOP_INSTR;
            if (target_bad) begin
                // Keep pc word-aligned; HALT never requests again, so any response is dropped.
                mis_n    = 1'b1;
                squash_n = 1'b0;
                state_n  = HALT;
            end else begin
                pc_n = redirect_pc;
                case (state_q)
                    FETCH: begin
                        if (imem_gnt) begin
                            state_n  = WAIT;
                            squash_n = 1'b1;
                        end
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            state_n  = FETCH;
                            squash_n = 1'b0;
                        end else begin
                            squash_n = 1'b1;
                        end
                    end
                    default: state_n = FETCH;
                endcase
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_gnt) state_n = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (squash_q) begin
                            squash_n = 1'b0;
                            state_n  = FETCH;
                        end else begin
                            instr_n    = imem_rdata;
                            instr_pc_n = pc_q;
                            state_n    = VALID;
                        end
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        pc_n    = pc_q + 32'd4;
                        state_n = FETCH;
                    end
                end
                default: state_n = HALT;
            endcase
        end
    end

    assign imem_req    = reset && (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == VALID);
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = instr_pc_q + 32'd4;
    assign misaligned  = mis_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: normal fetch, gnt stall, redirects, wrap, misaligned halt, reset.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         reset;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic [31:0]  instr;
    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  instr_pc;
    logic [31:0]  pc_plus4;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         misaligned;
    fetch_state_t state_dbg;

    int compared   = 0;
    int mismatched = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_pc    (instr_pc),
        .pc_plus4    (pc_plus4),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .misaligned  (misaligned),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Entered at a negedge with the DUT in FETCH at address a; leaves it in FETCH at a+4.
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, a);
        imem_gnt = 1'b1;
        @(negedge clk);
        check("wait_req", {31'd0, imem_req}, 32'd0);
        check("wait_valid", {31'd0, instr_valid}, 32'd0);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        @(negedge clk);
        check("valid_flag", {31'd0, instr_valid}, 32'd1);
        check("valid_instr", instr, d);
        check("valid_pc", instr_pc, a);
        check("valid_pc4", pc_plus4, a + 32'd4);
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // 1: back-to-back fetches at 0,4,8,C
        fetch_one(32'h0, 32'h0010_0093);
        fetch_one(32'h4, 32'h0020_0113);
        fetch_one(32'h8, 32'h0030_0193);
        fetch_one(32'hC, 32'h0040_0213);

        // 2: gnt withheld for 5 cycles, address must stay put
        for (int i = 0; i < 5; i++) begin
            check("stall_req", {31'd0, imem_req}, 32'd1);
            check("stall_addr", imem_addr, 32'h10);
            @(negedge clk);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        check("stall_wait", {30'd0, state_dbg}, {30'd0, WAIT});
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0293;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("t3_valid", {31'd0, instr_valid}, 32'd1);
        check("t3_pc", instr_pc, 32'h10);

        // 3: redirect in VALID beats instr_ready
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        instr_ready = 1'b1;
        @(negedge clk);
        redirect    = 1'b0;
        instr_ready = 1'b0;
        check("t3_addr", imem_addr, 32'h100);
        check("t3_req", {31'd0, imem_req}, 32'd1);
        check("t3_vld0", {31'd0, instr_valid}, 32'd0);
        check("t3_nop", instr, NOP);

        // 4: redirect during WAIT squashes the returning word
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        check("t4_wait", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("t4_vld0", {31'd0, instr_valid}, 32'd0);
        check("t4_instr", instr, NOP);
        fetch_one(32'h200, 32'h0060_0313);

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        fetch_one(32'hFFFF_FFFC, 32'h0070_0393);
        check("wrap_addr", imem_addr, 32'h0);

        // 5: misaligned redirect halts; stray gnt/rvalid ignored
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
        check("t5_mis", {31'd0, misaligned}, 32'd1);
        check("t5_req", {31'd0, imem_req}, 32'd0);
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_hreq", {31'd0, imem_req}, 32'd0);
            check("t5_hvld", {31'd0, instr_valid}, 32'd0);
            check("t5_hmis", {31'd0, misaligned}, 32'd1);
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("t5_clr", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        // rvalid with nothing outstanding is ignored
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("t5_stray", {31'd0, instr_valid}, 32'd0);
        fetch_one(32'h0, 32'h0080_0413);

        // 6: reset asserted mid-WAIT
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("t6_req", {31'd0, imem_req}, 32'd0);
        check("t6_instr", instr, NOP);
        check("t6_pc", instr_pc, 32'd0);
        check("t6_state", {30'd0, state_dbg}, {30'd0, FETCH});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_req1", {31'd0, imem_req}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
